tx_frame_sched: RTL and testbench

Frame scheduler between the ADC capture stage and the UART transmitter `tx_sys`. It snapshots the four channel readings and four channel maxima, then sequences them into a framed packet: header, sequence number, payload and checksum. It issues one byte at a time over the `send`/`ready` handshake. Frames start on a capture strobe or on an internal periodic tick.

---
 rtl/comm_pkg.sv | 25 ++
 rtl/tick_gen.sv | 30 +++
 rtl/tx_frame_sched.sv | 151 +++++++++++++++
 tb/tb_tx_frame_sched.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/comm_pkg.sv
// Shared types and constants for the frame scheduler.
// Frame layout: header, seq, payload, checksum.
package comm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE,
    NEXT
  } state_e;

  localparam logic [7:0] FRAME_HDR = 8'hA5;
  localparam int FRAME_LEN_MAX = 11;
  localparam int FRAME_LEN_MIN = 7;

  function automatic logic [3:0] last_idx(
    input bit inc_max
  );
    return inc_max ? 4'(FRAME_LEN_MAX - 1)
                   : 4'(FRAME_LEN_MIN - 1);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running period counter; one-clock tick on wrap.
// PERIOD = 0 ties the tick off.
module tick_gen #(
  parameter int PERIOD = 0
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  if (PERIOD == 0) begin : g_off
    logic unused_in;
    assign unused_in = clock ^ reset;
    assign tick = 1'b0;
  end else begin : g_on
    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
      tick  = (cnt_q == CW'(PERIOD - 1));
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clock) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tx_frame_sched.sv
// Snapshots channel data and streams it as a checksummed
// frame to the UART transmitter, one byte per handshake.
module tx_frame_sched
  import comm_pkg::*;
#(
  parameter int PERIOD      = 0,
  parameter bit INCLUDE_MAX = 1,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        capture,
  input  logic [31:0] ch_data,
  input  logic [31:0] ch_max,
  input  logic        tx_ready,
  output logic        send,
  output logic [7:0]  data,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun,
  output logic        tx_error
);

  localparam logic [3:0] LAST = last_idx(INCLUDE_MAX);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  state_e        state_q, state_d;
  logic [7:0]    seq_q, seq_d;
  logic          pend_q, pend_d;
  logic [3:0]    idx_q, idx_d;
  logic [7:0]    csum_q, csum_d;
  logic [63:0]   buf_q, buf_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic       tick;
  logic       trig;
  logic [2:0] pidx;
  logic [7:0] byte_sel;

  tick_gen #(.PERIOD(PERIOD)) u_tick (
    .clock (clock),
    .reset (reset),
    .tick  (tick)
  );

  assign trig = capture | tick;

  always_comb begin
    pidx = 3'(idx_q - 4'd2);
    unique case (1'b1)
      (idx_q == 4'd0): byte_sel = FRAME_HDR;
      (idx_q == 4'd1): byte_sel = seq_q;
      (idx_q == LAST): byte_sel = csum_q;
      default:         byte_sel = buf_q[{pidx, 3'b000} +: 8];
    endcase
  end

  always_comb begin
    state_d    = state_q;
    seq_d      = seq_q;
    pend_d     = pend_q;
    idx_d      = idx_q;
    csum_d     = csum_q;
    buf_d      = buf_q;
    tmo_d      = tmo_q;
    send       = 1'b0;
    frame_done = 1'b0;
    overrun    = 1'b0;
    tx_error   = 1'b0;

    // Only one trigger can be queued behind the running frame.
    if (state_q != IDLE && trig) begin
      if (pend_q) overrun = 1'b1;
      else        pend_d  = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (trig || pend_q) state_d = LOAD;
      end
      LOAD: begin
        buf_d   = {ch_max, ch_data};
        idx_d   = '0;
        csum_d  = '0;
        state_d = ISSUE;
      end
      ISSUE: begin
        if (tx_ready) begin
          send    = 1'b1;
          tmo_d   = '0;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (!tx_ready) begin
          state_d = WAIT_DONE;
        end else if (tmo_q == TW'(ACK_TIMEOUT - 1)) begin
          tx_error = 1'b1;
          state_d  = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (tx_ready) begin
          if (idx_q != 4'd0 && idx_q != LAST)
            csum_d = csum_q + byte_sel;
          state_d = NEXT;
        end
      end
      NEXT: begin
        if (idx_q == LAST) begin
          frame_done = 1'b1;
          seq_d      = seq_q + 8'd1;
          state_d    = (pend_q || trig) ? LOAD : IDLE;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == LOAD) pend_d = 1'b0;
  end

  assign busy = (state_q != IDLE);
  assign data = (state_q inside {ISSUE, WAIT_ACK, WAIT_DONE})
              ? byte_sel : 8'h00;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      seq_q   <= '0;
      pend_q  <= 1'b0;
      idx_q   <= '0;
      csum_q  <= '0;
      buf_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      pend_q  <= pend_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      buf_q   <= buf_d;
      tmo_q   <= tmo_d;
    end
  end

endmodule

// File: tb/tb_tx_frame_sched.sv
// Scoreboard bench for tx_frame_sched: three instances
// (default, readings-only, periodic) with transmitter models.
module tb_tx_frame_sched;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err = 0;

  function automatic void chk(input string nm,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  logic        rst_a = 1'b0;
  logic        rst_bc = 1'b0;
  logic        cap_a = 1'b0;
  logic        cap_b = 1'b0;
  logic        cap_c = 1'b0;
  logic        no_ack = 1'b0;
  logic [31:0] ch_data = '0;
  logic [31:0] ch_max = '0;
  logic [31:0] ch_data_c = 32'h04030201;
  logic [31:0] ch_max_c = 32'h0;

  logic       send_a, busy_a, fd_a, ov_a, err_a, rdy_a;
  logic       send_b, busy_b, fd_b, ov_b, err_b, rdy_b;
  logic       send_c, busy_c, fd_c, ov_c, err_c, rdy_c;
  logic [7:0] data_a, data_b, data_c;

  tx_frame_sched u_a (
    .clock(clock), .reset(rst_a), .capture(cap_a),
    .ch_data(ch_data), .ch_max(ch_max), .tx_ready(rdy_a),
    .send(send_a), .data(data_a), .busy(busy_a),
    .frame_done(fd_a), .overrun(ov_a), .tx_error(err_a)
  );

  tx_frame_sched #(.INCLUDE_MAX(0)) u_b (
    .clock(clock), .reset(rst_bc), .capture(cap_b),
    .ch_data(ch_data), .ch_max(ch_max), .tx_ready(rdy_b),
    .send(send_b), .data(data_b), .busy(busy_b),
    .frame_done(fd_b), .overrun(ov_b), .tx_error(err_b)
  );

  tx_frame_sched #(.PERIOD(100)) u_c (
    .clock(clock), .reset(rst_bc), .capture(cap_c),
    .ch_data(ch_data_c), .ch_max(ch_max_c), .tx_ready(rdy_c),
    .send(send_c), .data(data_c), .busy(busy_c),
    .frame_done(fd_c), .overrun(ov_c), .tx_error(err_c)
  );

  // Transmitter models: ready drops after send, returns later.
  int hc_a, hc_b;
  always @(posedge clock) begin
    if (!rst_a) begin
      rdy_a <= 1'b1; hc_a <= 0;
    end else if (send_a && !no_ack) begin
      rdy_a <= 1'b0; hc_a <= 3;
    end else if (!rdy_a) begin
      if (hc_a == 0) rdy_a <= 1'b1;
      else hc_a <= hc_a - 1;
    end
  end

  always @(posedge clock) begin
    if (!rst_bc) begin
      rdy_b <= 1'b1; hc_b <= 0;
    end else if (send_b) begin
      rdy_b <= 1'b0; hc_b <= 1;
    end else if (!rdy_b) begin
      if (hc_b == 0) rdy_b <= 1'b1;
      else hc_b <= hc_b - 1;
    end
  end

  always @(posedge clock) begin
    if (!rst_bc) rdy_c <= 1'b1;
    else if (send_c) rdy_c <= 1'b0;
    else rdy_c <= 1'b1;
  end

  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  logic [7:0] exp_c[$];

  int fd_cnt_a = 0, ov_cnt_a = 0, err_cnt_a = 0;
  int fd_cnt_b = 0, ov_cnt_b = 0;
  int fd_cnt_c = 0, ov_cnt_c = 0, err_cnt_c = 0;
  int nsend_a = 0, send_cyc_a = 0, err_cyc_a = 0;
  int c_bytes = 0, c_hdr = 0, c_last_hdr = 0;

  always @(negedge clock) begin
    logic [7:0] e;
    if (send_a === 1'b1) begin
      chk("a_send_ready", {31'd0, rdy_a}, 1);
      if (exp_a.size() == 0) begin
        chk("a_unexpected_byte", {24'd0, data_a}, 32'hFFFF);
      end else begin
        e = exp_a.pop_front();
        chk("a_byte", {24'd0, data_a}, {24'd0, e});
      end
      nsend_a++;
      send_cyc_a = cyc;
    end
    if (fd_a === 1'b1) fd_cnt_a++;
    if (ov_a === 1'b1) ov_cnt_a++;
    if (err_a === 1'b1) begin
      err_cnt_a++;
      err_cyc_a = cyc;
    end
  end

  always @(negedge clock) begin
    logic [7:0] e;
    if (send_b === 1'b1) begin
      if (exp_b.size() == 0) begin
        chk("b_unexpected_byte", {24'd0, data_b}, 32'hFFFF);
      end else begin
        e = exp_b.pop_front();
        chk("b_byte", {24'd0, data_b}, {24'd0, e});
      end
    end
    if (fd_b === 1'b1) fd_cnt_b++;
    if (ov_b === 1'b1) ov_cnt_b++;
  end

  always @(negedge clock) begin
    logic [7:0] e;
    if (send_c === 1'b1) begin
      if (exp_c.size() == 0) begin
        chk("c_unexpected_byte", {24'd0, data_c}, 32'hFFFF);
      end else begin
        e = exp_c.pop_front();
        chk("c_byte", {24'd0, data_c}, {24'd0, e});
      end
      if (c_bytes % 11 == 0) begin
        if (c_hdr > 0) chk("c_period", cyc - c_last_hdr, 100);
        c_last_hdr = cyc;
        c_hdr++;
      end
      c_bytes++;
    end
    if (fd_c === 1'b1) fd_cnt_c++;
    if (ov_c === 1'b1) ov_cnt_c++;
    if (err_c === 1'b1) err_cnt_c++;
  end

  function automatic int get_cnt(input int id);
    case (id)
      0: return fd_cnt_a;
      1: return fd_cnt_b;
      2: return fd_cnt_c;
      3: return err_cnt_a;
      default: return nsend_a;
    endcase
  endfunction

  task automatic wait_cnt(input string nm, input int id,
                          input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clock);
      #1;
      if (get_cnt(id) >= target) break;
    end
    chk(nm, get_cnt(id), target);
  endtask

  task automatic push_bytes(input int q, input logic [87:0] v,
                            input int n);
    for (int i = 0; i < n; i++) begin
      if (q == 0) exp_a.push_back(v[8*(n-1-i) +: 8]);
      else exp_b.push_back(v[8*(n-1-i) +: 8]);
    end
  endtask

  task automatic pulse_a();
    @(negedge clock);
    cap_a = 1'b1;
    @(negedge clock);
    cap_a = 1'b0;
  endtask

  task automatic chk_quiet_a(input string tag);
    chk({tag, "_send"}, {31'd0, send_a}, 0);
    chk({tag, "_busy"}, {31'd0, busy_a}, 0);
    chk({tag, "_data"}, {24'd0, data_a}, 0);
    chk({tag, "_frame_done"}, {31'd0, fd_a}, 0);
    chk({tag, "_overrun"}, {31'd0, ov_a}, 0);
    chk({tag, "_tx_error"}, {31'd0, err_a}, 0);
  endtask

  initial begin
    logic [7:0] s;
    for (int f = 0; f < 257; f++) begin
      s = 8'(f);
      exp_c.push_back(8'hA5);
      exp_c.push_back(s);
      for (int k = 1; k <= 4; k++) exp_c.push_back(8'(k));
      for (int k = 0; k < 4; k++) exp_c.push_back(8'h00);
      exp_c.push_back(s + 8'h0A);
    end

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk_quiet_a("reset");
    rst_a = 1'b1;
    rst_bc = 1'b1;

    // Single frame on both a and b; inputs change after snapshot.
    ch_data = 32'h40302010;
    ch_max = 32'h44332211;
    push_bytes(0, 88'hA5_00_10_20_30_40_11_22_33_44_4A, 11);
    push_bytes(1, 88'hA5_00_10_20_30_40_A0, 7);
    @(negedge clock);
    cap_a = 1'b1;
    cap_b = 1'b1;
    @(posedge clock);
    @(negedge clock);
    cap_a = 1'b0;
    cap_b = 1'b0;
    @(posedge clock);
    #1;
    chk("a_first_send_latency", {31'd0, send_a}, 1);
    @(negedge clock);
    ch_data = 32'hFFFFFFFF;
    ch_max = 32'hFFFFFFFF;
    wait_cnt("a_frame1_done", 0, 1, 400);
    wait_cnt("b_frame1_done", 1, 1, 400);
    chk("a_queue_after_frame1", exp_a.size(), 0);
    chk("b_queue_after_frame1", exp_b.size(), 0);
    chk("b_overrun_count", ov_cnt_b, 0);

    // Start plus two triggers mid-frame: one queued, one dropped.
    ch_data = 32'h04030201;
    ch_max = 32'h08070605;
    push_bytes(0, 88'hA5_01_01_02_03_04_05_06_07_08_25, 11);
    push_bytes(0, 88'hA5_02_01_02_03_04_05_06_07_08_26, 11);
    pulse_a();
    repeat (20) @(negedge clock);
    pulse_a();
    repeat (20) @(negedge clock);
    pulse_a();
    wait_cnt("a_b2b_frames_done", 0, 3, 800);
    repeat (5) @(posedge clock);
    #1;
    chk("a_b2b_overrun_count", ov_cnt_a, 1);
    chk("a_b2b_idle_busy", {31'd0, busy_a}, 0);
    chk("a_queue_after_b2b", exp_a.size(), 0);

    // No acknowledge: abort after timeout, seq unchanged.
    no_ack = 1'b1;
    push_bytes(0, 88'hA5, 1);
    pulse_a();
    wait_cnt("a_timeout_error", 3, 1, 200);
    chk("a_timeout_delay", err_cyc_a - send_cyc_a, 64);
    chk("a_timeout_idle", {31'd0, busy_a}, 0);
    chk("a_timeout_no_done", fd_cnt_a, 3);
    no_ack = 1'b0;
    push_bytes(0, 88'hA5_03_01_02_03_04_05_06_07_08_27, 11);
    pulse_a();
    wait_cnt("a_retry_done", 0, 4, 400);
    chk("a_queue_after_retry", exp_a.size(), 0);

    // Reset after byte 4 of a frame.
    push_bytes(0, 88'hA5_04_01_02_03, 5);
    pulse_a();
    wait_cnt("a_partial_sends", 4, nsend_a + 5, 400);
    @(negedge clock);
    rst_a = 1'b0;
    @(posedge clock);
    #1;
    chk_quiet_a("midreset");
    @(negedge clock);
    rst_a = 1'b1;
    chk("a_midreset_no_done", fd_cnt_a, 4);
    chk("a_midreset_no_error", err_cnt_a, 1);
    chk("a_queue_after_partial", exp_a.size(), 0);
    push_bytes(0, 88'hA5_00_01_02_03_04_05_06_07_08_24, 11);
    pulse_a();
    wait_cnt("a_post_reset_done", 0, 5, 400);
    chk("a_queue_final", exp_a.size(), 0);

    // Periodic instance: 257 frames, seq wraps FF to 00.
    wait_cnt("c_frames_done", 2, 257, 30000);
    chk("c_queue_final", exp_c.size(), 0);
    chk("c_overrun_count", ov_cnt_c, 0);
    chk("c_error_count", err_cnt_c, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
